inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 158 +++++++++++++++
 tb/tb_inst_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a length-prefixed, checksummed byte image
// and writes it word by word into instruction memory while holding the CPU in reset.
module inst_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_lenHi;
   logic [15:0] r_len;
   logic [15:0] r_idx;
   logic [31:0] r_asm;
   logic [1:0]  r_byteCnt;
   logic [7:0]  r_csum;
   logic [31:0] r_memAddr;
   logic [31:0] r_memWdata;

   logic        w_accept;
   logic        w_restart;
   logic [15:0] w_lenNext;
   logic        w_lenBad;
   logic [31:0] w_asmNext;

   assign w_accept  = in_valid && in_ready;
   assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
   assign w_lenNext = {r_lenHi, in_data};
   assign w_lenBad  = (w_lenNext == 16'd0) || ({16'd0, w_lenNext} > 32'(MAX_WORDS));
   assign w_asmNext = {r_asm[23:0], in_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      err      = 1'b0;
      case (r_state)
         S_IDLE: begin
            cpu_hold = 1'b0;
            if (start) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (w_accept) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (w_accept) w_next = w_lenBad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (w_accept && r_byteCnt == 2'd3) w_next = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            w_next = (r_idx + 16'd1 == r_len) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            in_ready = 1'b1;
            if (w_accept) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
         end
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) w_next = S_LEN_HI;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) w_next = S_LEN_HI;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address and data are latched with the 4th byte so they are stable for the
   // whole WRITE cycle and simply hold afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lenHi    <= 8'd0;
         r_len      <= 16'd0;
         r_idx      <= 16'd0;
         r_asm      <= 32'd0;
         r_byteCnt  <= 2'd0;
         r_csum     <= 8'd0;
         r_memAddr  <= 32'd0;
         r_memWdata <= 32'd0;
      end else begin
         if (w_restart) begin
            r_idx     <= 16'd0;
            r_csum    <= 8'd0;
            r_asm     <= 32'd0;
            r_byteCnt <= 2'd0;
         end
         if (w_accept) begin
            case (r_state)
               S_LEN_HI: begin
                  r_lenHi <= in_data;
                  r_csum  <= r_csum ^ in_data;
               end
               S_LEN_LO: begin
                  r_len  <= w_lenNext;
                  r_csum <= r_csum ^ in_data;
               end
               S_DATA: begin
                  r_asm     <= w_asmNext;
                  r_byteCnt <= r_byteCnt + 2'd1;
                  r_csum    <= r_csum ^ in_data;
                  if (r_byteCnt == 2'd3) begin
                     r_memAddr  <= ADDR_BASE + {14'd0, r_idx, 2'b00};
                     r_memWdata <= w_asmNext;
                  end
               end
               default: ;
            endcase
         end
         if (r_state == S_WRITE) begin
            r_idx <= r_idx + 16'd1;
         end
      end
   end

   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: expected memory writes are queued when an
// image is issued and a monitor pops them whenever the loader strobes mem_we.
module tb_inst_loader;

   localparam int TB_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         expQ[$];
   logic [31:0] imgWords[$];
   int          nChecks = 0;
   int          nFails = 0;

   always #5 clk = ~clk;

   inst_loader #(
      .ADDR_BASE (32'h0000_0000),
      .MAX_WORDS (TB_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of the scoreboard; between writes the
   // memory bus must hold the last written address/data (or zero after reset).
   initial begin
      logic [31:0] lastA;
      logic [31:0] lastD;
      bit          wasRst;
      wr_t         e;
      lastA = 32'd0;
      lastD = 32'd0;
      forever begin
         @(posedge clk);
         wasRst = rst;
         @(negedge clk);
         if (wasRst) begin
            lastA = 32'd0;
            lastD = 32'd0;
         end else if (mem_we) begin
            checkOutput("in_ready_during_write", {31'd0, in_ready}, 32'd0);
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
               e = expQ.pop_front();
               checkOutput("write_addr", mem_addr, e.a);
               checkOutput("write_data", mem_wdata, e.d);
               lastA = e.a;
               lastD = e.d;
            end
         end else begin
            checkOutput("hold_addr", mem_addr, lastA);
            checkOutput("hold_data", mem_wdata, lastD);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int guard;
      bit acc;
      while ($urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      forever begin
         acc = in_ready;
         @(negedge clk);
         if (acc) break;
         guard++;
         if (guard > 50) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL byte_timeout: got in_ready 0 expected 1 within 50 cycles");
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Issues one image built from n and imgWords; the model decides which writes and
   // which final status the loader owes.
   task automatic applyStimulus(input int n, input bit badCsum, input bit injectStart);
      logic [7:0]  bytes[$];
      logic [7:0]  csum;
      logic [31:0] w;
      bit          lenOk;
      bit          good;
      int          nSend;
      lenOk = (n >= 1) && (n <= TB_MAX);
      bytes.push_back(8'(n >> 8));
      bytes.push_back(8'(n));
      if (lenOk) begin
         for (int i = 0; i < n; i++) begin
            w = imgWords[i];
            for (int j = 0; j < 4; j++) bytes.push_back(w[31 - 8 * j -: 8]);
            expQ.push_back('{a: 32'(4 * i), d: w});
         end
      end
      csum = 8'd0;
      foreach (bytes[k]) csum = csum ^ bytes[k];
      bytes.push_back(badCsum ? (csum ^ 8'(1 + $urandom_range(0, 254))) : csum);
      good  = lenOk && !badCsum;
      nSend = lenOk ? bytes.size() : 2;
      pulseStart();
      checkOutput("done_cleared", {31'd0, done}, 32'd0);
      checkOutput("err_cleared", {31'd0, err}, 32'd0);
      for (int k = 0; k < nSend; k++) begin
         sendByte(bytes[k]);
         if (injectStart && k == 5) pulseStart();
      end
      checkOutput("done", {31'd0, done}, {31'd0, good});
      checkOutput("err", {31'd0, err}, {31'd0, !good});
      checkOutput("cpu_hold", {31'd0, cpu_hold}, {31'd0, !good});
      checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("writes_outstanding", expQ.size(), 32'd0);
      checkOutput("status_held", {30'd0, done, err}, {30'd0, good, !good});
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Bytes offered while idle must be ignored.
      repeat (3) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
         checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("idle_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      end
      in_valid = 1'b0;

      imgWords = '{32'hDEADBEEF};
      applyStimulus(1, 1'b0, 1'b0);

      imgWords = '{32'h11223344, 32'h55667788};
      applyStimulus(2, 1'b0, 1'b0);

      applyStimulus(0, 1'b0, 1'b0);
      imgWords = '{32'hCAFEF00D};
      applyStimulus(1, 1'b0, 1'b0);

      applyStimulus(5, 1'b0, 1'b0);
      imgWords = '{32'h01020304, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000};
      applyStimulus(4, 1'b0, 1'b0);

      imgWords = '{32'h87654321};
      applyStimulus(1, 1'b1, 1'b0);

      imgWords = '{32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F};
      applyStimulus(3, 1'b0, 1'b1);

      // Abort mid-load: the first word lands, the second never does.
      pulseStart();
      expQ.push_back('{a: 32'h0, d: 32'hAABBCCDD});
      sendByte(8'h00);
      sendByte(8'h02);
      sendByte(8'hAA);
      sendByte(8'hBB);
      sendByte(8'hCC);
      sendByte(8'hDD);
      sendByte(8'h12);
      sendByte(8'h34);
      rst = 1'b1;
      @(negedge clk);
      checkAllZero("abort");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_no_more_writes", expQ.size(), 32'd0);

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 7))
            0:       n = 0;
            1:       n = TB_MAX + 1 + $urandom_range(0, 60000);
            default: n = $urandom_range(1, TB_MAX);
         endcase
         imgWords.delete();
         for (int i = 0; i < TB_MAX; i++) imgWords.push_back($urandom);
         applyStimulus(n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
